// File: rtl/trdb_pkg.sv
// Shared trace-decoder types: packet format/type codes, decoder FSM states, link sizing.
package trdb_pkg;

    localparam int PAYLOAD_LEN  = 256;
    localparam int P_LEN        = 5;
    localparam int HDR_RSVD_LEN = 3;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } it_format_e;

    typedef enum logic [3:0] {
        F0SF0 = 4'h0,
        F0SF1 = 4'h1,
        F1    = 4'h4,
        F2    = 4'h8,
        F3SF0 = 4'hC,
        F3SF1 = 4'hD,
        F3SF2 = 4'hE,
        F3SF3 = 4'hF
    } it_packet_type_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DISCARD = 2'd2,
        OUT     = 2'd3
    } trdb_dec_state_e;

    // Type code is {format, subformat}; only sync packets carry a 2-bit subformat.
    function automatic it_packet_type_e trdb_classify(input logic [1:0] fmt,
                                                      input logic [1:0] sf_bits);
        it_packet_type_e t;
        case (fmt)
            F_OPT_EXT:    t = sf_bits[0] ? F0SF1 : F0SF0;
            F_DIFF_DELTA: t = F1;
            F_ADDR_ONLY:  t = F2;
            default:      t = it_packet_type_e'({2'b11, sf_bits});
        endcase
        return t;
    endfunction

endpackage

// File: rtl/trdb_packet_decoder.sv
// Reassembles length-prefixed trace packets from a byte stream and classifies them.
// Latency: pkt_valid_o rises the cycle after the last payload byte; one bubble per packet.
// Backpressure: byte_ready_o low while a decoded packet waits for pkt_ready_i.
module trdb_packet_decoder
    import trdb_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   byte_valid_i,
    output logic                   byte_ready_o,
    input  logic [7:0]             byte_data_i,
    output logic                   pkt_valid_o,
    input  logic                   pkt_ready_i,
    output logic [3:0]             pkt_type_o,
    output logic [P_LEN-1:0]       pkt_len_o,
    output logic [PAYLOAD_LEN-1:0] pkt_payload_o,
    output logic                   err_o
);

    localparam int IDX_W = P_LEN + 3;

    trdb_dec_state_e         state_q;
    logic [P_LEN-1:0]        len_q;
    logic [P_LEN-1:0]        cnt_q;
    logic [PAYLOAD_LEN-1:0]  buf_q;
    logic                    valid_q;
    logic                    err_q;

    logic                    byte_acc;
    logic [P_LEN-1:0]        hdr_len;
    logic [HDR_RSVD_LEN-1:0] hdr_rsvd;
    logic [IDX_W-1:0]        wr_bit;

    assign byte_ready_o = (state_q != OUT);
    assign byte_acc     = byte_valid_i & byte_ready_o;
    assign hdr_len      = byte_data_i[P_LEN-1:0];
    assign hdr_rsvd     = byte_data_i[7:P_LEN];
    assign wr_bit       = {cnt_q, 3'b000};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (flush_i) begin
                // Abort wins over everything, including a byte presented this cycle.
                state_q <= IDLE;
                len_q   <= '0;
                cnt_q   <= '0;
                buf_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (byte_acc) begin
                            if (hdr_rsvd != '0) begin
                                err_q   <= 1'b1;
                                cnt_q   <= hdr_len;
                                state_q <= (hdr_len == '0) ? IDLE : DISCARD;
                            end else if (hdr_len == '0) begin
                                err_q <= 1'b1;
                            end else begin
                                buf_q   <= '0;
                                len_q   <= hdr_len;
                                cnt_q   <= '0;
                                state_q <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (byte_acc) begin
                            buf_q[wr_bit +: 8] <= byte_data_i;
                            cnt_q              <= cnt_q + P_LEN'(1);
                            if (cnt_q == len_q - P_LEN'(1)) begin
                                state_q <= OUT;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    DISCARD: begin
                        if (byte_acc) begin
                            cnt_q <= cnt_q - P_LEN'(1);
                            if (cnt_q == P_LEN'(1)) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    OUT: begin
                        if (pkt_ready_i) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pkt_valid_o   = valid_q;
    assign err_o         = err_q;
    assign pkt_len_o     = len_q;
    assign pkt_payload_o = buf_q;
    assign pkt_type_o    = valid_q ? trdb_classify(buf_q[1:0], buf_q[3:2]) : 4'h0;

endmodule

// File: tb/tb_trdb_packet_decoder.sv
// Scoreboard bench for trdb_packet_decoder: directed cases then randomized packet stream.
module tb_trdb_packet_decoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         byte_valid;
    logic         byte_ready;
    logic [7:0]   byte_data;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [3:0]   pkt_type;
    logic [4:0]   pkt_len;
    logic [255:0] pkt_payload;
    logic         err;

    typedef struct packed {
        logic [3:0]   typ;
        logic [4:0]   len;
        logic [255:0] pay;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pl[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         exp_err = 0;
    int         obs_err = 0;
    bit         hold_ready = 1'b0;

    always #5 clk = ~clk;

    trdb_packet_decoder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .byte_valid_i  (byte_valid),
        .byte_ready_o  (byte_ready),
        .byte_data_i   (byte_data),
        .pkt_valid_o   (pkt_valid),
        .pkt_ready_i   (pkt_ready),
        .pkt_type_o    (pkt_type),
        .pkt_len_o     (pkt_len),
        .pkt_payload_o (pkt_payload),
        .err_o         (err)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference classification straight from the format/subformat rules.
    function automatic logic [3:0] ref_type(input logic [7:0] b0);
        int fmt;
        int sf;
        fmt = int'(b0) % 4;
        sf  = (int'(b0) / 4) % 4;
        if (fmt == 0) return 4'(sf % 2);
        if (fmt == 1) return 4'd4;
        if (fmt == 2) return 4'd8;
        return 4'(12 + sf);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        budget     = 0;
        while (!byte_ready && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (!byte_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept_timeout: byte_ready_o=%0b, required 1", byte_ready);
            byte_valid = 1'b0;
        end else begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    // Sends header plus the bytes in pl; the model's expectation is queued first.
    task automatic send_packet(input logic [7:0] hdr, input bit gaps);
        exp_t e;
        int   n;
        bit   bad;
        n   = int'(hdr[4:0]);
        bad = (hdr[7:5] != 3'b000) || (n == 0);
        if (bad) begin
            exp_err++;
        end else begin
            e.typ = ref_type(pl[0]);
            e.len = hdr[4:0];
            e.pay = '0;
            for (int k = 0; k < n; k++) e.pay[8*k +: 8] = pl[k];
            exp_q.push_back(e);
        end
        send_byte(hdr, gaps);
        check("err_after_hdr", err, bad);
        foreach (pl[k]) send_byte(pl[k], gaps);
        if (!bad) check("valid_latency", pkt_valid, 1);
    endtask

    task automatic wait_drained();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || pkt_valid) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        pkt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pkt_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every output handshake, checks hold stability.
    initial begin
        exp_t e;
        exp_t snap;
        bit   snap_vld;
        snap_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (err) obs_err++;
                if (err || pkt_valid) check("err_valid_exclusive", err & pkt_valid, 0);
                if (!pkt_valid) check("type_zero_idle", pkt_type, 0);
                if (pkt_valid) check("byte_ready_in_out", byte_ready, 0);
                if (pkt_valid && snap_vld) begin
                    check("hold_type", pkt_type, snap.typ);
                    check("hold_len", pkt_len, snap.len);
                    check("hold_payload", pkt_payload, snap.pay);
                end
                if (pkt_valid && pkt_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_pkt: got type %h len %0d, required no packet", pkt_type, pkt_len);
                    end else begin
                        e = exp_q.pop_front();
                        check("pkt_type", pkt_type, e.typ);
                        check("pkt_len", pkt_len, e.len);
                        check("pkt_payload", pkt_payload, e.pay);
                    end
                    snap_vld = 1'b0;
                end else if (pkt_valid) begin
                    snap.typ = pkt_type;
                    snap.len = pkt_len;
                    snap.pay = pkt_payload;
                    snap_vld = 1'b1;
                end else begin
                    snap_vld = 1'b0;
                end
            end else begin
                snap_vld = 1'b0;
            end
        end
    end

    initial begin
        int         kind;
        int         n;
        logic [7:0] hdr;

        rst_n      = 1'b0;
        flush      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #12;
        check("rst_valid", pkt_valid, 0);
        check("rst_err", err, 0);
        check("rst_byte_ready", byte_ready, 1);
        check("rst_type", pkt_type, 0);
        check("rst_len", pkt_len, 0);
        check("rst_payload", pkt_payload, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Sync packet, three bytes.
        pl.delete(); pl.push_back(8'h0F); pl.push_back(8'hAA); pl.push_back(8'h55);
        send_packet(8'h03, 1'b0);
        wait_drained();

        pl.delete(); pl.push_back(8'h05);
        send_packet(8'h01, 1'b0);
        wait_drained();

        // Consumer stalls for 10 cycles with a stray byte offered meanwhile.
        hold_ready = 1'b1;
        @(negedge clk);
        pl.delete(); pl.push_back(8'h04); pl.push_back(8'h01);
        send_packet(8'h02, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'hC3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", pkt_valid, 1);
            check("hold_byte_ready", byte_ready, 0);
        end
        byte_valid = 1'b0;
        hold_ready = 1'b0;
        wait_drained();

        pl.delete();
        send_packet(8'h00, 1'b1);
        pl.delete(); pl.push_back(8'h02);
        send_packet(8'h01, 1'b1);
        wait_drained();

        pl.delete(); pl.push_back(8'h13); pl.push_back(8'h27); pl.push_back(8'h3B);
        send_packet(8'h23, 1'b1);
        pl.delete(); pl.push_back(8'h03);
        send_packet(8'h01, 1'b1);
        wait_drained();

        pl.delete();
        for (int k = 0; k < 31; k++) pl.push_back(8'(k));
        send_packet(8'h1F, 1'b0);
        wait_drained();

        // Flush mid-payload, with a byte offered in the flush cycle.
        send_byte(8'h04, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        flush      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        @(negedge clk);
        flush      = 1'b0;
        byte_valid = 1'b0;
        check("flush_no_valid", pkt_valid, 0);
        check("flush_no_err", err, 0);
        check("flush_byte_ready", byte_ready, 1);
        pl.delete(); pl.push_back(8'h0B); pl.push_back(8'h22); pl.push_back(8'h33); pl.push_back(8'h44);
        send_packet(8'h04, 1'b0);
        wait_drained();

        // Flush while a packet is waiting: it must be withdrawn.
        hold_ready = 1'b1;
        @(negedge clk);
        pl.delete(); pl.push_back(8'h01);
        send_packet(8'h01, 1'b0);
        void'(exp_q.pop_back());
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_out_valid_drop", pkt_valid, 0);
        check("flush_out_type", pkt_type, 0);
        hold_ready = 1'b0;

        // Asynchronous reset mid-payload.
        send_byte(8'h05, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", pkt_valid, 0);
        check("arst_err", err, 0);
        check("arst_len", pkt_len, 0);
        check("arst_payload", pkt_payload, 0);
        check("arst_byte_ready", byte_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int p = 0; p < 150; p++) begin
            kind = $urandom_range(0, 9);
            n    = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 4) : $urandom_range(1, 31);
            if (kind == 0) hdr = 8'h00;
            else if (kind == 1) hdr = {3'($urandom_range(1, 7)), 5'($urandom_range(0, 31))};
            else hdr = {3'b000, 5'(n)};
            n = int'(hdr[4:0]);
            pl.delete();
            for (int k = 0; k < n; k++) pl.push_back(8'($urandom));
            send_packet(hdr, 1'b1);
        end
        wait_drained();
        repeat (3) @(negedge clk);
        check("err_count", obs_err, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
